scan_sequencer: RTL and testbench



---
 rtl/scan_sequencer.sv | 160 ++++++++++++++++
 tb/tb_scan_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Channel sequencer for the 3-to-8 decoder: walks the set bits of a captured mask, holding each for dwell+1 cycles.
// Optional feature macro SCAN_BLANK_EN inserts a one-cycle blank (enable low) between consecutive channels.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               enable,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1
`ifdef SCAN_BLANK_EN
    , ST_BLANK = 2'd2
`endif
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  // Lowest set bit of m; an empty mask never reaches this in practice.
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      res = m[i] ? 3'(i) : res;
    end
    return res;
  endfunction

  // {found, index} of the nearest set bit strictly above s.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] s);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      res = (m[i] && (i > int'(s))) ? {1'b1, 3'(i)} : res;
    end
    return res;
  endfunction

  state_t             state_r, state_s;
  logic [2:0]         sel_r, sel_s;
  logic [DWELL_W-1:0] cnt_r, cnt_s;
  logic [DWELL_W-1:0] dwell_r, dwell_s;
  logic [7:0]         mask_r, mask_s;
  logic               mode_r, mode_s;
  logic               enable_r, enable_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [3:0]         next_s;

  assign next_s = next_above(mask_r, sel_r);

  // Next-state and next-output logic; outputs are computed here and registered below.
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    cnt_s    = cnt_r;
    mask_s   = mask_r;
    dwell_s  = dwell_r;
    mode_s   = mode_r;
    enable_s = 1'b0;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop && (mask != 8'd0)) begin
          mask_s   = mask;
          dwell_s  = dwell;
          mode_s   = mode;
          sel_s    = lowest_bit(mask);
          cnt_s    = dwell;
          state_s  = ST_DWELL;
          enable_s = 1'b1;
          busy_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (cnt_r != CNT_ZERO) begin
          cnt_s    = cnt_r - CNT_ONE;
          enable_s = 1'b1;
          busy_s   = 1'b1;
        end else if (next_s[3] || mode_r) begin
          // Wrap to the lowest bit only in continuous mode; a single-bit mask re-enters itself.
          sel_s  = next_s[3] ? next_s[2:0] : lowest_bit(mask_r);
          cnt_s  = dwell_r;
          busy_s = 1'b1;
`ifdef SCAN_BLANK_EN
          state_s  = ST_BLANK;
          enable_s = 1'b0;
`else
          state_s  = ST_DWELL;
          enable_s = 1'b1;
`endif
        end else begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end
      end
`ifdef SCAN_BLANK_EN
      ST_BLANK: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else begin
          state_s  = ST_DWELL;
          enable_s = 1'b1;
          busy_s   = 1'b1;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      sel_r    <= 3'd0;
      cnt_r    <= CNT_ZERO;
      mask_r   <= 8'd0;
      dwell_r  <= CNT_ZERO;
      mode_r   <= 1'b0;
      enable_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      sel_r    <= sel_s;
      cnt_r    <= cnt_s;
      mask_r   <= mask_s;
      dwell_r  <= dwell_s;
      mode_r   <= mode_s;
      enable_r <= enable_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign sel    = sel_r;
  assign enable = enable_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer; expected outputs are hand-derived per cycle.
// Honours SCAN_BLANK_EN by expecting one blank cycle before every channel after the first.
module tb_scan_sequencer;

`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       enable;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .mask   (mask),
    .dwell  (dwell),
    .sel    (sel),
    .enable (enable),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] s, input logic en,
                           input logic b, input logic d);
    check({tag, ".sel"},    {5'd0, sel},    {5'd0, s});
    check({tag, ".enable"}, {7'd0, enable}, {7'd0, en});
    check({tag, ".busy"},   {7'd0, busy},   {7'd0, b});
    check({tag, ".done"},   {7'd0, done},   {7'd0, d});
  endtask

  // Checks one channel visit (optional leading blank, then `cycles` enabled cycles), advancing the clock.
  task automatic expect_channel(input string tag, input logic [2:0] ch, input int cycles,
                                input bit not_first);
    if (BLANK && not_first) begin
      check_out({tag, "_blank"}, ch, 1'b0, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < cycles; i++) begin
      check_out(tag, ch, 1'b1, 1'b1, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    mask  = 8'd0;
    dwell = 8'd0;

    // Reset, then idle with start low
    tick();
    tick();
    check_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_out("idle1", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("idle2", 3'd0, 1'b0, 1'b0, 1'b0);

    // Single sweep over channels 0,2,5,7 with two cycles each
    mask  = 8'hA5;
    dwell = 8'd1;
    mode  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_channel("sweep0", 3'd0, 2, 1'b0);
    expect_channel("sweep2", 3'd2, 2, 1'b1);
    expect_channel("sweep5", 3'd5, 2, 1'b1);
    expect_channel("sweep7", 3'd7, 2, 1'b1);
    check_out("sweep_done", 3'd7, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("sweep_idle", 3'd7, 1'b0, 1'b0, 1'b0);

    // Continuous 0,7,0,7,... with stop during the sixth channel
    mask  = 8'h81;
    dwell = 8'd0;
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_channel("cont_a", 3'd0, 1, 1'b0);
    expect_channel("cont_b", 3'd7, 1, 1'b1);
    expect_channel("cont_c", 3'd0, 1, 1'b1);
    expect_channel("cont_d", 3'd7, 1, 1'b1);
    expect_channel("cont_e", 3'd0, 1, 1'b1);
    if (BLANK) begin
      check_out("cont_f_blank", 3'd7, 1'b0, 1'b1, 1'b0);
      tick();
    end
    check_out("cont_f", 3'd7, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_out("cont_stop", 3'd7, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("cont_nodone", 3'd7, 1'b0, 1'b0, 1'b0);

    // Start with an empty mask is ignored
    mask  = 8'd0;
    mode  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_out("mask0", 3'd7, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("mask0_hold", 3'd7, 1'b0, 1'b0, 1'b0);

    // Start together with stop: stop wins
    mask  = 8'hFF;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_out("startstop", 3'd7, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("startstop_hold", 3'd7, 1'b0, 1'b0, 1'b0);

    // Captured settings are used despite input changes and extra start pulses
    mask  = 8'h06;
    dwell = 8'd2;
    mode  = 1'b0;
    start = 1'b1;
    tick();
    mask  = 8'hFF;
    dwell = 8'd0;
    mode  = 1'b1;
    expect_channel("capt1", 3'd1, 3, 1'b0);
    start = 1'b0;
    expect_channel("capt2", 3'd2, 3, 1'b1);
    check_out("capt_done", 3'd2, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("capt_idle", 3'd2, 1'b0, 1'b0, 1'b0);

    // Reset mid-dwell overrides simultaneous start and stop
    mask  = 8'h06;
    dwell = 8'd2;
    mode  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_out("rst_pre", 3'd1, 1'b1, 1'b1, 1'b0);
    tick();
    stop  = 1'b1;
    start = 1'b1;
    rst_n = 1'b0;
    tick();
    check_out("rst_mid", 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    stop  = 1'b0;
    start = 1'b0;
    tick();
    check_out("rst_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Maximum dwell: 256 cycles on channel 4
    mask  = 8'h10;
    dwell = 8'hFF;
    mode  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_channel("long4", 3'd4, 256, 1'b0);
    check_out("long_done", 3'd4, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("long_idle", 3'd4, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
